// File: rtl/rf_sweep_pkg.sv
// Shared definitions for the RF sweep master: default RF geometry, op and state encodings,
// and the per-pair mismatch helper used by the readback check.
package rf_sweep_pkg;

    localparam int DEF_DBITS = 32;
    localparam int DEF_REGS  = 16;
    localparam int DEF_AW    = 4;

    typedef enum logic [1:0] {
        OP_DUMP       = 2'b00,
        OP_FILL_CONST = 2'b01,
        OP_FILL_FIB   = 2'b10,
        OP_CHECK_FIB  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_EMIT0 = 3'd3,
        ST_EMIT1 = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    function automatic logic [1:0] pair_miss(input logic lo_bad, input logic hi_bad);
        return {1'b0, lo_bad} + {1'b0, hi_bad};
    endfunction

endpackage

// File: rtl/rf_sweep_master_if.sv
// RF pin set plus dump stream; the sweep master owns the master side, the RF/sink the slave side.
interface rf_sweep_master_if
    import rf_sweep_pkg::*;
#(
    parameter int DBITS = DEF_DBITS,
    parameter int AW    = DEF_AW
);
    logic             WrEn;
    logic [AW-1:0]    RD;
    logic [DBITS-1:0] WrData;
    logic [AW-1:0]    RS1;
    logic [AW-1:0]    RS2;
    logic [DBITS-1:0] out1;
    logic [DBITS-1:0] out2;
    logic             out_valid;
    logic             out_ready;
    logic [DBITS-1:0] out_data;
    logic [AW-1:0]    out_idx;

    modport master (
        output WrEn, RD, WrData, RS1, RS2, out_valid, out_data, out_idx,
        input  out1, out2, out_ready
    );

    modport slave (
        input  WrEn, RD, WrData, RS1, RS2, out_valid, out_data, out_idx,
        output out1, out2, out_ready
    );
endinterface

// File: rtl/rf_sweep_master_fib_gen.sv
// Fibonacci term generator: holds fib(n) and fib(n+1); step advances by one term, step2 by two.
module fib_gen #(
    parameter int DBITS = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             step2_i,
    output logic [DBITS-1:0] cur_o,
    output logic [DBITS-1:0] nxt_o
);
    logic [DBITS-1:0] a_q, b_q, a_d, b_d;

    // Next term pair selection
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load_i) begin
            a_d = DBITS'(1);
            b_d = DBITS'(1);
        end else if (step2_i) begin
            a_d = a_q + b_q;
            b_d = a_q + b_q + b_q;
        end else if (step_i) begin
            a_d = b_q;
            b_d = a_q + b_q;
        end else begin
            a_d = a_q;
            b_d = b_q;
        end
    end

    // Term registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_q <= DBITS'(1);
            b_q <= DBITS'(1);
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign cur_o = a_q;
    assign nxt_o = b_q;
endmodule

// File: rtl/rf_sweep_master.sv
// Boot/debug sweep engine for a 16x32 register file: constant fill, Fibonacci fill, dump, check.
// Build option: define RF_SWEEP_CHECK_EN to include the CHECK_FIB compare path and err_cnt counter.
module rf_sweep_master
    import rf_sweep_pkg::*;
#(
    parameter int DBITS = DEF_DBITS,
    parameter int REGS  = DEF_REGS,
    parameter int AW    = DEF_AW
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DBITS-1:0]  seed,
    output logic              busy,
    output logic              done,
    output logic [4:0]        err_cnt,
    rf_sweep_master_if.master bus
);
    state_e           state_q, state_d;
    op_e              op_q, op_s;
    logic [DBITS-1:0] seed_q, buf0_q, buf1_q;
    logic [AW-1:0]    idx_q;
    logic [4:0]       err_q;
    logic [DBITS-1:0] fib_cur_s, fib_nxt_s;
    logic             accept_s, is_fill_s, last_reg_s, last_pair_s;
    logic [AW-1:0]    pair_lo_s, pair_hi_s;
    logic             wr_en_s, out_valid_s;
    logic [AW-1:0]    rd_s, rs1_s, rs2_s, out_idx_s;
    logic [DBITS-1:0] wr_data_s, out_data_s;

    assign op_s        = op_e'(op);
    assign accept_s    = (state_q == ST_IDLE) && start;
    assign is_fill_s   = (op_s == OP_FILL_CONST) || (op_s == OP_FILL_FIB);
    assign last_reg_s  = (idx_q == AW'(REGS - 1));
    assign last_pair_s = (idx_q == AW'(REGS / 2 - 1));
    // During READ/EMIT idx_q counts register pairs, not registers
    assign pair_lo_s   = {idx_q[AW-2:0], 1'b0};
    assign pair_hi_s   = {idx_q[AW-2:0], 1'b1};

    fib_gen #(.DBITS(DBITS)) u_fib (
        .CLK     (CLK),
        .RESET   (RESET),
        .load_i  (accept_s),
        .step_i  (state_q == ST_WRITE),
        .step2_i ((state_q == ST_READ) && (op_q == OP_CHECK_FIB)),
        .cur_o   (fib_cur_s),
        .nxt_o   (fib_nxt_s)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_fill_s) state_d = ST_WRITE;
                    else           state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (last_reg_s) state_d = ST_DONE;
                else            state_d = ST_WRITE;
            end
            ST_READ: begin
                if (op_q == OP_DUMP)  state_d = ST_EMIT0;
`ifdef RF_SWEEP_CHECK_EN
                else if (last_pair_s) state_d = ST_DONE;
                else                  state_d = ST_READ;
`else
                else                  state_d = ST_DONE;
`endif
            end
            ST_EMIT0: begin
                if (bus.out_ready) state_d = ST_EMIT1;
                else               state_d = ST_EMIT0;
            end
            ST_EMIT1: begin
                if (!bus.out_ready)   state_d = ST_EMIT1;
                else if (last_pair_s) state_d = ST_DONE;
                else                  state_d = ST_READ;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operation latch, index counter and dump buffer
    always_ff @(posedge CLK) begin
        if (RESET) begin
            op_q   <= OP_DUMP;
            seed_q <= {DBITS{1'b0}};
            idx_q  <= {AW{1'b0}};
            buf0_q <= {DBITS{1'b0}};
            buf1_q <= {DBITS{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q   <= op_s;
                        seed_q <= seed;
                        idx_q  <= {AW{1'b0}};
                    end
                end
                ST_WRITE: idx_q <= idx_q + AW'(1);
                ST_READ: begin
                    if (op_q == OP_DUMP) begin
                        buf0_q <= bus.out1;
                        buf1_q <= bus.out2;
                    end else begin
                        idx_q <= idx_q + AW'(1);
                    end
                end
                ST_EMIT1: begin
                    if (bus.out_ready) idx_q <= idx_q + AW'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef RF_SWEEP_CHECK_EN
    // Mismatch counter, cleared by each accepted start
    always_ff @(posedge CLK) begin
        if (RESET) begin
            err_q <= 5'd0;
        end else if (accept_s) begin
            err_q <= 5'd0;
        end else if ((state_q == ST_READ) && (op_q == OP_CHECK_FIB)) begin
            err_q <= err_q + {3'b000, pair_miss(bus.out1 != fib_cur_s, bus.out2 != fib_nxt_s)};
        end
    end
`else
    logic unused_s;
    assign err_q    = 5'd0;
    assign unused_s = ^fib_nxt_s;
`endif

    // Output decode from registered state
    always_comb begin
        wr_en_s     = 1'b0;
        rd_s        = {AW{1'b0}};
        wr_data_s   = {DBITS{1'b0}};
        rs1_s       = {AW{1'b0}};
        rs2_s       = {AW{1'b0}};
        out_valid_s = 1'b0;
        out_data_s  = {DBITS{1'b0}};
        out_idx_s   = {AW{1'b0}};
        case (state_q)
            ST_WRITE: begin
                wr_en_s = 1'b1;
                rd_s    = idx_q;
                if (op_q == OP_FILL_CONST) wr_data_s = seed_q;
                else                       wr_data_s = fib_cur_s;
            end
            ST_READ: begin
`ifdef RF_SWEEP_CHECK_EN
                rs1_s = pair_lo_s;
                rs2_s = pair_hi_s;
`else
                if (op_q == OP_DUMP) begin
                    rs1_s = pair_lo_s;
                    rs2_s = pair_hi_s;
                end else begin
                    rs1_s = {AW{1'b0}};
                    rs2_s = {AW{1'b0}};
                end
`endif
            end
            ST_EMIT0: begin
                out_valid_s = 1'b1;
                out_data_s  = buf0_q;
                out_idx_s   = pair_lo_s;
            end
            ST_EMIT1: begin
                out_valid_s = 1'b1;
                out_data_s  = buf1_q;
                out_idx_s   = pair_hi_s;
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // RESET gates the write strobe so the edge that resets the FSM cannot also commit a write
    assign bus.WrEn      = wr_en_s & ~RESET;
    assign bus.RD        = rd_s;
    assign bus.WrData    = wr_data_s;
    assign bus.RS1       = rs1_s;
    assign bus.RS2       = rs2_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = out_data_s;
    assign bus.out_idx   = out_idx_s;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign err_cnt       = err_q;
endmodule

// File: tb/tb_rf_sweep_master.sv
// Bench for rf_sweep_master: behavioural 16x32 RF, scoreboard of expected dump beats and done
// times, randomized fills/corruptions/ready patterns checked against a register-file model.
module tb_rf_sweep_master;
    import rf_sweep_pkg::*;

    localparam int DBITS = 32;
    localparam int REGS  = 16;
    localparam int AW    = 4;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] data;
    } beat_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] seed = 32'd0;
    logic        busy, done;
    logic [4:0]  err_cnt;
    logic        rdy = 1'b1;
    int          rdy_mode = 0;

    logic        bd_we = 1'b0;
    logic [3:0]  bd_addr = 4'd0;
    logic [31:0] bd_data = 32'd0;
    logic [31:0] rf [REGS];
    logic [31:0] model [REGS];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_total = 0;
    int done_cnt = 0;
    beat_t exp_q[$];
    int    done_q[$];

    rf_sweep_master_if #(.DBITS(DBITS), .AW(AW)) bus ();

    rf_sweep_master #(.DBITS(DBITS), .REGS(REGS), .AW(AW)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .start   (start),
        .op      (op),
        .seed    (seed),
        .busy    (busy),
        .done    (done),
        .err_cnt (err_cnt),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        if (bus.WrEn)      rf[bus.RD] <= bus.WrData;
        else if (bd_we)    rf[bd_addr] <= bd_data;
    end
    assign bus.out1      = rf[bus.RS1];
    assign bus.out2      = rf[bus.RS2];
    assign bus.out_ready = rdy;

    function automatic logic [31:0] fib(int n);
        logic [31:0] a = 32'd1;
        logic [31:0] b = 32'd1;
        logic [31:0] t;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Ready pattern driver: steady, one-in-three, or random
    initial begin
        int ph = 0;
        forever begin
            @(posedge CLK);
            #2;
            case (rdy_mode)
                0: rdy = 1'b1;
                1: begin ph = (ph + 1) % 3; rdy = (ph == 0); end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: done timing, dump beats and stall stability
    initial begin
        logic        held_v = 1'b0;
        logic [31:0] held_d = 32'd0;
        logic [3:0]  held_i = 4'd0;
        beat_t       b;
        int          t;
        forever begin
            @(negedge CLK);
            if (bus.WrEn) wr_total++;
            if (done) begin
                done_cnt++;
                if (done_q.size() == 0) fail("unexpected_done");
                else begin
                    t = done_q.pop_front();
                    if (t >= 0) chk("done_cycle", 32'(cyc), 32'(t));
                end
            end
            if (bus.out_valid && !RESET) begin
                if (held_v) begin
                    chk("stall_data", bus.out_data, held_d);
                    chk("stall_idx", 32'(bus.out_idx), 32'(held_i));
                end
                if (bus.out_ready) begin
                    held_v = 1'b0;
                    if (exp_q.size() == 0) fail("unexpected_beat");
                    else begin
                        b = exp_q.pop_front();
                        chk("beat_idx", 32'(bus.out_idx), 32'(b.idx));
                        chk("beat_data", bus.out_data, b.data);
                    end
                end else begin
                    held_v = 1'b1;
                    held_d = bus.out_data;
                    held_i = bus.out_idx;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic bd_write(input int a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = 4'(a); bd_data = d;
        @(negedge CLK);
        bd_we = 1'b0;
        model[a] = d;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] s, input int lat);
        op = o; seed = s; start = 1'b1;
        done_q.push_back((lat > 0) ? cyc + lat : -1);
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_done(input int tgt);
        int n = 0;
        while (done_cnt < tgt && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        if (done_cnt < tgt) fail("done_timeout");
        tick(1);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] s, input int lat, output int wr);
        int w0 = wr_total;
        int tgt = done_cnt + 1;
        issue(o, s, lat);
        wait_done(tgt);
        wr = wr_total - w0;
    endtask

    task automatic push_dump();
        for (int i = 0; i < REGS; i++) exp_q.push_back('{idx: 4'(i), data: model[i]});
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < REGS; i++) chk($sformatf("%s_r%0d", tag, i), rf[i], model[i]);
    endtask

    task automatic fill_fib_model();
        for (int i = 0; i < REGS; i++) model[i] = fib(i);
    endtask

    function automatic int fib_errors();
        int e = 0;
        for (int i = 0; i < REGS; i++) if (model[i] != fib(i)) e++;
        return e;
    endfunction

    initial begin
        int wr, lat_chk, e, w0, n;
        logic [31:0] s, fib_ref [9];
        fib_ref = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34};
`ifdef RF_SWEEP_CHECK_EN
        lat_chk = REGS / 2 + 1;
`else
        lat_chk = 2;
`endif
        tick(1);
        for (int i = 0; i < REGS; i++) bd_write(i, $urandom);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_wren", 32'(bus.WrEn), 32'd0);
        chk("rst_sel", {20'd0, bus.RS1, bus.RS2, bus.RD}, 32'd0);
        chk("rst_wrdata", bus.WrData, 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_odata", bus.out_data, 32'd0);
        chk("rst_oidx", 32'(bus.out_idx), 32'd0);
        check_rf("preload");
        RESET = 1'b0;
        tick(2);

        run_op(2'b10, $urandom, REGS + 1, wr);
        chk("fib_wr_cycles", 32'(wr), 32'(REGS));
        for (int i = 0; i < 9; i++) chk($sformatf("fib_table_r%0d", i), rf[i], fib_ref[i]);
        fill_fib_model();
        check_rf("fib");

        run_op(2'b01, 32'd42, REGS + 1, wr);
        for (int i = 0; i < REGS; i++) model[i] = 32'd42;
        check_rf("const42");
        push_dump();
        run_op(2'b00, $urandom, 3 * REGS / 2 + 1, wr);
        chk("dump_no_write", 32'(wr), 32'd0);

        for (int r = 0; r < 3; r++) begin
            s = $urandom;
            run_op(2'b01, s, REGS + 1, wr);
            for (int i = 0; i < REGS; i++) model[i] = s;
            for (int k = 0; k < 4; k++) bd_write($urandom_range(0, REGS - 1), $urandom);
            rdy_mode = (r == 0) ? 1 : 2;
            push_dump();
            run_op(2'b00, $urandom, -1, wr);
            chk("dump_stall_no_write", 32'(wr), 32'd0);
            rdy_mode = 0;
        end

        run_op(2'b10, 32'd0, REGS + 1, wr);
        fill_fib_model();
        bd_write(5, 32'd0);
`ifdef RF_SWEEP_CHECK_EN
        e = fib_errors();
`else
        e = 0;
`endif
        run_op(2'b11, 32'd0, lat_chk, wr);
        chk("check_r5_err", 32'(err_cnt), 32'(e));
        chk("check_no_write", 32'(wr), 32'd0);

        for (int r = 0; r < 3; r++) begin
            run_op(2'b10, 32'd0, REGS + 1, wr);
            fill_fib_model();
            for (int k = 0; k < 1 + r * 3; k++) bd_write($urandom_range(0, REGS - 1), $urandom);
`ifdef RF_SWEEP_CHECK_EN
            e = fib_errors();
`else
            e = 0;
`endif
            run_op(2'b11, 32'd0, lat_chk, wr);
            chk("check_rand_err", 32'(err_cnt), 32'(e));
        end

`ifdef RF_SWEEP_CHECK_EN
        run_op(2'b10, 32'd0, REGS + 1, wr);
        fill_fib_model();
        bd_write(5, 32'd0);
        w0 = wr_total;
        n = done_cnt + 1;
        issue(2'b11, 32'd0, lat_chk);
        tick(4);
        op = 2'b01; seed = 32'hDEAD_BEEF; start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(n);
        chk("busy_start_err_kept", 32'(err_cnt), 32'd1);
        chk("busy_start_no_write", 32'(wr_total - w0), 32'd0);
`endif

        push_dump();
        w0 = wr_total;
        n = done_cnt + 1;
        issue(2'b00, 32'd0, 3 * REGS / 2 + 1);
        tick(6);
        op = 2'b01; seed = 32'hDEAD_BEEF; start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(n);
        chk("busy_dump_no_write", 32'(wr_total - w0), 32'd0);
        check_rf("after_busy_dump");

        // Start held on the DONE cycle must not launch a second fill
        w0 = wr_total;
        issue(2'b01, 32'd9, REGS + 1);
        n = 0;
        while (!done && n < 100) begin @(negedge CLK); n++; end
        if (!done) fail("done_wait_timeout");
        op = 2'b01; seed = 32'd5; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(20);
        for (int i = 0; i < REGS; i++) model[i] = 32'd9;
        chk("done_start_writes", 32'(wr_total - w0), 32'(REGS));
        check_rf("done_start");

        run_op(2'b10, 32'd0, REGS + 1, wr);
        fill_fib_model();
        op = 2'b01; seed = 32'd7; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        RESET = 1'b1;
        tick(1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_wren", 32'(bus.WrEn), 32'd0);
        chk("midrst_bus", {20'd0, bus.RS1, bus.RS2, bus.RD}, 32'd0);
        chk("midrst_wrdata", bus.WrData, 32'd0);
        chk("midrst_done_err", {26'd0, done, err_cnt}, 32'd0);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        RESET = 1'b0;
        tick(2);
        for (int i = 0; i < 3; i++) model[i] = 32'd7;
        check_rf("midrst");

        chk("beats_left", 32'(exp_q.size()), 32'd0);
        chk("dones_left", 32'(done_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
